mpu_alu: RTL and testbench
==========================

# mpu_alu

Arithmetic/logic unit of the MPU (memory protection/monitoring unit) core. It evaluates one operation per clock on two 64-bit operands and two 64-bit mask operands at a selectable operand width (8/16/32/64 bits). It returns a registered 64-bit result and an 8-bit flag vector. The MPU instruction datapath uses it for mask matching, masked comparison, ordering tests and plain arithmetic.

## Interface
Parameters: none.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- size  in  2  operand width: 0 = 8, 1 = 16, 2 = 32, 3 = 64 bits.
- op  in  4  operation select.
- a  in  64  operand A.
- b  in  64  operand B.
- m0  in  64  mask 0: "must be 0" mask for MASK, compare mask for CMP.
- m1  in  64  mask 1: "must be 1" mask for MASK.
- res  out  64  registered result.
- flags  out  8  registered flags: [0] Z, [1] C, [2] N, [3] T (predicate true), [4] ILL (illegal op), [7:5] always 0.

## Operation
- Width W is selected by size. Only bits [W-1:0] of a, b, m0 and m1 are used; higher bits are ignored.
- The result is computed at width W. Bits [63:W] of res are always 0.
- Operations:
  - 0 PASS: res = a.
  - 1 MASK: predicate true iff every bit i < W satisfies (a[i] & m1[i]) | (!a[i] & m0[i]). A bit set in both m0 and m1 is therefore don't-care.
  - 2 CMP: predicate true iff ((a ^ b) & m0) == 0 over W bits.
  - 3 LT: predicate true iff a < b, unsigned, over W bits.
  - 4 AND, 5 OR, 6 XOR: bitwise.
  - 7 ADD: C = carry out of bit W-1.
  - 8 SUB: a - b; C = borrow (a < b unsigned).
  - 9 NOT: ~a.
  - A SHL: a << b[5:0].
  - B SHR: logical a >> b[5:0].
  - C..F: illegal.
- Shift rule: a shift count of W or more gives 0.
- Predicate ops (1–3): res = {63'b0, T}.
- Illegal op: res = 0, ILL = 1, Z = 1, all other flags 0.
- Flag rules:
  - Z = (res[W-1:0] == 0).
  - N = res[W-1].
  - C is meaningful only for ADD and SUB; 0 for all other ops.
  - T is meaningful only for ops 1–3; 0 for all other ops.

## Timing
- Combinational evaluation, then a single output register: res/flags reflect inputs sampled at rising edge k, visible after edge k.
- Latency 1 cycle, throughput one op per cycle, no handshake. Inputs are sampled every cycle.
- Reset is asynchronous (sys_rst_n low):
  - res = 0 and flags = 0 immediately.
  - Held for as long as reset is asserted.
  - The first valid output appears one edge after deassertion.
- Reset mid-operation discards the in-flight result.
- Changing size or op between cycles has no carry-over effect; there is no internal state beyond the output register.

## Configuration
- MPU_ALU_SHIFT_EN defined: ops A (SHL) and B (SHR) are implemented as specified.
- MPU_ALU_SHIFT_EN undefined: no shifter is built, and ops A/B behave as illegal ops (res = 0, ILL = 1, Z = 1).

## Test plan
- MASK, size 0: a=0x55, m0=0xAA, m1=0x55 -> res=1, T=1. Same with m1=0x15 -> res=0, T=0, Z=1. Same with m0=0x2A (m1=0x55) -> res=0, T=0.
- CMP, size 0: a=0x55, b=0x55, m0=0xFF -> T=1. Then b=0x54, m0=0xFF -> T=0. Then b=0x54, m0=0xFE -> T=1.
- LT, size 0: a=0x54, b=0x55 -> T=1. a=0x55, b=0x55 -> T=0. With a=0x155, b=0x055 (upper bits ignored) -> T=0.
- ADD/SUB width wrap:
  - size 0, ADD a=0xFF, b=0x01 -> res=0, Z=1, C=1.
  - size 3, SUB a=0, b=1 -> res=0xFFFF_FFFF_FFFF_FFFF, N=1, C=1.
- Illegal op and reset:
  - op=0xE -> res=0, ILL=1.
  - Assert sys_rst_n=0 between clock edges -> res and flags go to 0 without waiting for a clock edge.
  - After release, the output reappears one edge later.
- Shifts (macro defined): size 1, SHL a=0x0001, b=15 -> res=0x8000, N=1. b=16 -> res=0, Z=1. With the macro undefined, the same stimulus -> ILL=1.

Source files
------------

// File: rtl/mpu_alu.sv
// mpu_alu: width-selectable (8/16/32/64) ALU for the MPU datapath. It handles mask match, masked compare, ordering and arithmetic.
// Latency: 1 cycle. Inputs are sampled every rising edge and res/flags are registered.
// Backpressure: none. It accepts one op per cycle with no handshake.
//
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset (clears res/flags)
//   size [1:0]         : operand width 0=8, 1=16, 2=32, 3=64 bits
//   op   [3:0]         : operation select (0xC..0xF illegal)
//   a, b [63:0]        : operands
//   m0, m1 [63:0]      : masks ("must be 0" / compare mask, "must be 1")
//   res  [63:0]        : registered result, bits above the width forced to 0
//   flags [7:0]        : {3'b0, ILL, T, N, C, Z}
//
// Build option: define MPU_ALU_SHIFT_EN to implement SHL/SHR (ops 0xA/0xB).
// Without it no shifter is built, and those ops report ILL like ops 0xC..0xF.
module mpu_alu (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  size,
  input  logic [3:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] m0,
  input  logic [63:0] m1,
  output logic [63:0] res,
  output logic [7:0]  flags
);

  typedef enum logic [3:0] {
    OP_PASS = 4'h0,
    OP_MASK = 4'h1,
    OP_CMP  = 4'h2,
    OP_LT   = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_ADD  = 4'h7,
    OP_SUB  = 4'h8,
    OP_NOT  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB
  } alu_op_e;

  logic [63:0] res_q, res_d;
  logic [7:0]  flags_q, flags_d;

  logic [63:0] wmask;      // ones in bits [W-1:0]
  logic [6:0]  wbits;      // W
  logic [5:0]  msb_idx;    // W-1
  logic [63:0] a_w, b_w, m0_w, m1_w;
  logic [64:0] sum;
  logic [63:0] diff;
  logic        t_d, c_d, ill_d, z_d, n_d;

  always_comb begin
    case (size)
      2'd0:    begin wmask = 64'h0000_0000_0000_00FF; wbits = 7'd8;  msb_idx = 6'd7;  end
      2'd1:    begin wmask = 64'h0000_0000_0000_FFFF; wbits = 7'd16; msb_idx = 6'd15; end
      2'd2:    begin wmask = 64'h0000_0000_FFFF_FFFF; wbits = 7'd32; msb_idx = 6'd31; end
      default: begin wmask = 64'hFFFF_FFFF_FFFF_FFFF; wbits = 7'd64; msb_idx = 6'd63; end
    endcase
  end

  // Clearing the upper bits up front keeps ordering, compare and carry correct at W.
  assign a_w  = a  & wmask;
  assign b_w  = b  & wmask;
  assign m0_w = m0 & wmask;
  assign m1_w = m1 & wmask;
  assign sum  = {1'b0, a_w} + {1'b0, b_w};
  assign diff = a_w - b_w;

  always_comb begin
    res_d = 64'd0;
    t_d   = 1'b0;
    c_d   = 1'b0;
    ill_d = 1'b0;
    case (alu_op_e'(op))
      OP_PASS: res_d = a_w;
      // Each bit in W must be allowed by m1 (if a=1) or by m0 (if a=0).
      OP_MASK: begin
        t_d   = ((~((a_w & m1_w) | (~a_w & m0_w))) & wmask) == 64'd0;
        res_d = {63'd0, t_d};
      end
      OP_CMP: begin
        t_d   = ((a_w ^ b_w) & m0_w) == 64'd0;
        res_d = {63'd0, t_d};
      end
      OP_LT: begin
        t_d   = a_w < b_w;
        res_d = {63'd0, t_d};
      end
      OP_AND:  res_d = a_w & b_w;
      OP_OR:   res_d = a_w | b_w;
      OP_XOR:  res_d = a_w ^ b_w;
      OP_ADD: begin
        res_d = sum[63:0] & wmask;
        c_d   = sum[wbits];
      end
      OP_SUB: begin
        res_d = diff & wmask;
        c_d   = a_w < b_w;
      end
      OP_NOT:  res_d = ~a_w & wmask;
`ifdef MPU_ALU_SHIFT_EN
      // A count of W or more shifts everything out. W=64 is never reached by a 6-bit count.
      OP_SHL:  res_d = ({1'b0, b[5:0]} >= wbits) ? 64'd0 : ((a_w << b[5:0]) & wmask);
      OP_SHR:  res_d = ({1'b0, b[5:0]} >= wbits) ? 64'd0 : (a_w >> b[5:0]);
`endif
      default: ill_d = 1'b1;
    endcase
  end

  assign z_d = (res_d & wmask) == 64'd0;
  assign n_d = res_d[msb_idx];

  always_comb begin
    flags_d = {3'b000, ill_d, t_d, n_d, c_d, z_d};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      res_q   <= 64'd0;
      flags_q <= 8'd0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign res   = res_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_mpu_alu.sv
// tb_mpu_alu: directed vectors with hand-computed results for mpu_alu.
// Inputs are driven on the falling edge. Outputs are sampled 1ns after the rising edge.
module tb_mpu_alu;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [1:0]  size = '0;
  logic [3:0]  op = '0;
  logic [63:0] a = '0, b = '0, m0 = '0, m1 = '0;
  logic [63:0] res;
  logic [7:0]  flags;

  int n_checks = 0;
  int n_errors = 0;

  mpu_alu dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .size      (size),
    .op        (op),
    .a         (a),
    .b         (b),
    .m0        (m0),
    .m1        (m1),
    .res       (res),
    .flags     (flags)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [3:0] o, input logic [1:0] s, input logic [63:0] va,
                     input logic [63:0] vb, input logic [63:0] vm0, input logic [63:0] vm1);
    @(negedge sys_clk);
    op = o; size = s; a = va; b = vb; m0 = vm0; m1 = vm1;
    @(posedge sys_clk);
    #1;
  endtask

  // flags layout: {3'b0, ILL, T, N, C, Z}
  task automatic vec(input string tag, input logic [3:0] o, input logic [1:0] s,
                     input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vm0,
                     input logic [63:0] vm1, input logic [63:0] eres, input logic [7:0] eflg);
    run(o, s, va, vb, vm0, vm1);
    check({tag, ".res"}, res, eres);
    check({tag, ".flags"}, {56'd0, flags}, {56'd0, eflg});
  endtask

  initial begin
    // Reset state, before any clock edge and with reset still low.
    #2;
    check("reset.res", res, 64'd0);
    check("reset.flags", {56'd0, flags}, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // MASK
    vec("mask_ok",   4'h1, 2'd0, 64'h55, 64'h0, 64'hAA, 64'h55, 64'd1, 8'h08);
    vec("mask_m1",   4'h1, 2'd0, 64'h55, 64'h0, 64'hAA, 64'h15, 64'd0, 8'h01);
    vec("mask_m0",   4'h1, 2'd0, 64'h55, 64'h0, 64'h2A, 64'h55, 64'd0, 8'h01);
    // CMP
    vec("cmp_eq",    4'h2, 2'd0, 64'h55, 64'h55, 64'hFF, 64'h0, 64'd1, 8'h08);
    vec("cmp_ne",    4'h2, 2'd0, 64'h55, 64'h54, 64'hFF, 64'h0, 64'd0, 8'h01);
    vec("cmp_msk",   4'h2, 2'd0, 64'h55, 64'h54, 64'hFE, 64'h0, 64'd1, 8'h08);
    // LT
    vec("lt_true",   4'h3, 2'd0, 64'h54, 64'h55, 64'h0, 64'h0, 64'd1, 8'h08);
    vec("lt_eq",     4'h3, 2'd0, 64'h55, 64'h55, 64'h0, 64'h0, 64'd0, 8'h01);
    vec("lt_upper",  4'h3, 2'd0, 64'h155, 64'h055, 64'h0, 64'h0, 64'd0, 8'h01);
    // Arithmetic and width wrap
    vec("add_wrap",  4'h7, 2'd0, 64'hFF, 64'h01, 64'h0, 64'h0, 64'd0, 8'h03);
    vec("add_upper", 4'h7, 2'd0, 64'h1234, 64'h0011, 64'h0, 64'h0, 64'h45, 8'h00);
    vec("sub_borrow",4'h8, 2'd3, 64'h0, 64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h06);
    vec("sub_w16",   4'h8, 2'd1, 64'h0001_0005, 64'h3, 64'h0, 64'h0, 64'h2, 8'h00);
    // Logic ops
    vec("pass_w16",  4'h0, 2'd1, 64'hABCD_8001, 64'h0, 64'h0, 64'h0, 64'h8001, 8'h04);
    vec("and_w32",   4'h4, 2'd2, 64'hFFFF_FFFF_F0F0_F0F0, 64'hFF00_FF00, 64'h0, 64'h0, 64'hF000_F000, 8'h04);
    vec("or_w8",     4'h5, 2'd0, 64'h0F00, 64'h30, 64'h0, 64'h0, 64'h30, 8'h00);
    vec("xor_w32",   4'h6, 2'd2, 64'hFFFF_0000_1234_5678, 64'h0000_FFFF_1234_5678, 64'h0, 64'h0, 64'h0, 8'h01);
    vec("not_w8",    4'h9, 2'd0, 64'h0F, 64'h0, 64'h0, 64'h0, 64'hF0, 8'h04);
    // Illegal
    vec("illegal_e", 4'hE, 2'd3, 64'h1234, 64'h5678, 64'h0, 64'h0, 64'd0, 8'h11);
    vec("illegal_c", 4'hC, 2'd0, 64'hFF, 64'h1, 64'h0, 64'h0, 64'd0, 8'h11);
    // Shifts
`ifdef MPU_ALU_SHIFT_EN
    vec("shl_15",    4'hA, 2'd1, 64'h0001, 64'd15, 64'h0, 64'h0, 64'h8000, 8'h04);
    vec("shl_16",    4'hA, 2'd1, 64'h0001, 64'd16, 64'h0, 64'h0, 64'h0, 8'h01);
    vec("shr_15",    4'hB, 2'd1, 64'h8000, 64'd15, 64'h0, 64'h0, 64'h1, 8'h00);
    vec("shl_w64",   4'hA, 2'd3, 64'h1, 64'd63, 64'h0, 64'h0, 64'h8000_0000_0000_0000, 8'h04);
`else
    vec("shl_ill",   4'hA, 2'd1, 64'h0001, 64'd15, 64'h0, 64'h0, 64'd0, 8'h11);
    vec("shr_ill",   4'hB, 2'd1, 64'h8000, 64'd15, 64'h0, 64'h0, 64'd0, 8'h11);
`endif

    // Asynchronous reset in the middle of a cycle
    vec("pre_rst",   4'h0, 2'd0, 64'h77, 64'h0, 64'h0, 64'h0, 64'h77, 8'h00);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst.res", res, 64'd0);
    check("arst.flags", {56'd0, flags}, 64'd0);
    @(posedge sys_clk);
    #1;
    check("arst_hold.res", res, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("rel_noedge.res", res, 64'd0);
    @(posedge sys_clk);
    #1;
    check("rel_edge.res", res, 64'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
